apb_master_arbiter: RTL
=======================

# apb_master_arbiter

APB master that shares one APB bus among NUM_REQ requesters and sequences the SETUP/ACCESS phases toward NUM_SLV APB slaves. The block sits between internal requesters and the peripheral slaves:
- Round-robin arbitration picks one requester.
- The winner's address is decoded to a one-hot PSEL.
- The addressed slave's PRDATA/PREADY/PSLVERR are muxed back.
- Each requester gets grant and done pulses.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- NUM_REQ, 4, number of requesters (2..8)
- NUM_SLV, 4, number of slaves (1..8)
- SLV_SEL_LSB, 8, lowest address bit of the slave-select field; field width is $clog2(NUM_SLV), min 1
- TIMEOUT, 15, maximum ACCESS-phase cycles before abort (only with APB_TIMEOUT_EN)

Ports:
- i_pclk, in, 1, system clock
- i_prstn, in, 1, reset; asynchronous, active-low
- i_req, in, NUM_REQ, per-requester transfer request
- i_req_write, in, NUM_REQ, per-requester direction (1 = write)
- i_req_addr, in, NUM_REQ x ADDR_WIDTH, per-requester address
- i_req_wdata, in, NUM_REQ x DATA_WIDTH, per-requester write data
- o_gnt, out, NUM_REQ, one-hot, one-cycle pulse: request accepted
- o_done, out, NUM_REQ, one-hot, one-cycle pulse: transfer finished
- o_rdata, out, DATA_WIDTH, read data, valid with o_done
- o_err, out, 1, error status, valid with o_done
- o_paddr, out, ADDR_WIDTH, APB PADDR
- o_pwrite, out, 1, APB PWRITE
- o_psel, out, NUM_SLV, APB PSEL, one-hot
- o_penable, out, 1, APB PENABLE
- o_pwdata, out, DATA_WIDTH, APB PWDATA
- i_prdata, in, NUM_SLV x DATA_WIDTH, per-slave PRDATA
- i_pready, in, NUM_SLV, per-slave PREADY
- i_pslverr, in, NUM_SLV, per-slave PSLVERR

## Operation
- FSM states are IDLE, SETUP and ACCESS. Reset state is IDLE.
- **IDLE:**
  - If any i_req bit is high, choose a winner round-robin. The search starts at last_gnt+1 and wraps modulo NUM_REQ.
  - Register the winner's addr, write and wdata into o_paddr, o_pwrite and o_pwdata.
  - Decode slave index = addr[SLV_SEL_LSB +: $clog2(NUM_SLV)].
  - Drive o_psel one-hot and set o_gnt[winner] for one cycle. Go to SETUP.
- **SETUP:** o_psel held, o_penable=0. Go to ACCESS unconditionally.
- **ACCESS:** o_penable=1. At the first posedge with i_pready[idx]=1:
  - Capture i_prdata[idx] (reads only) into o_rdata, and i_pslverr[idx] into o_err.
  - Pulse o_done[winner], deassert o_psel/o_penable, go to IDLE.
- Unmapped slave (index >= NUM_SLV):
  - o_psel stays all-zero through SETUP/ACCESS.
  - ACCESS completes on its first edge with o_err=1 and o_rdata=0.
- o_rdata holds its last value after write transfers.
- last_gnt resets to NUM_REQ-1, so requester 0 wins first. It updates only on grant.
- Requesters hold i_req, addr, wdata and write stable until o_gnt. Dropping i_req before grant withdraws the request.
- A requester may re-request in the same cycle o_done is seen. It competes in that IDLE cycle.

## Timing
- Reset values, asserted asynchronously: o_psel=0, o_penable=0, o_paddr=0, o_pwrite=0, o_pwdata=0, o_gnt=0, o_done=0, o_rdata=0, o_err=0.
- Reset mid-transfer abandons the transfer silently. No o_done is produced.
- Zero-wait transfer, where edge 0 samples i_req in IDLE:
  - After edge 0: SETUP, with o_gnt high.
  - After edge 1: ACCESS, with o_penable high.
  - After edge 2: IDLE, with o_done, o_rdata and o_err valid.
- Minimum period is 3 cycles per transfer. Each extra cycle of PREADY low adds one cycle.
- o_gnt and o_done are registered, exactly one cycle wide, and never both high for the same transfer.
- Simultaneous requests in IDLE: exactly one grant. Losers keep requesting.
- i_pready of unselected slaves is ignored.

## Configuration
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - If i_pready[idx] is still low after TIMEOUT ACCESS cycles, the transfer ends: o_done pulses, o_err=1, o_rdata unchanged, FSM goes to IDLE.
  - A PREADY arriving on the TIMEOUT-th cycle completes normally.
- Undefined: no counter. ACCESS waits indefinitely for PREADY.

## Structure
- Shared package apb_pkg holds:
  - state enum apb_state_t {IDLE, SETUP, ACCESS}
  - function onehot_decode
  - localparam timeout-counter width = $clog2(TIMEOUT+1)
- One sub-module, apb_rr_arbiter:
  - Inputs: request vector, enable (FSM in IDLE).
  - Outputs: one-hot grant and binary index.
  - Owns the last_gnt pointer.
- Top module holds the FSM, APB registers and response mux.

## Test plan
- Reset, then requester 2 writes 0xDEADBEEF to 0x0000_0104 with zero-wait slaves -> o_psel=4'b0010, o_gnt[2] after edge 0, o_done[2] after edge 2, o_err=0, slave 1 word 1 updated.
- Requesters 0,1,3 request simultaneously and continuously -> grant order 0,1,3,0,1,3, one transfer per 3 cycles.
- Read from slave with 3 wait cycles returning 0x12345678 -> ACCESS lasts 4 cycles, o_rdata=0x12345678 with o_done, o_pwdata/o_paddr stable throughout.
- NUM_SLV=3, address slave field=3 -> no PSEL bit asserted, o_done after edge 2 with o_err=1, o_rdata=0.
- APB_TIMEOUT_EN, TIMEOUT=15, slave never ready -> o_done after 15 ACCESS cycles with o_err=1. Undefined: no o_done after 100 cycles.
- Assert i_prstn low during ACCESS -> all outputs 0 immediately, no o_done. After release, requester 0 wins first.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master/arbiter.
// State encoding, one-hot decode, timeout counter sizing.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int TMO_DEF = 15;
  localparam int TMO_W   = $clog2(TMO_DEF + 1);

  function automatic int tmo_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

  // Bit idx set only when idx addresses one of the n slaves.
  function automatic logic [7:0] onehot_decode(
    input logic [2:0] idx,
    input int         n
  );
    onehot_decode = '0;
    if (int'(idx) < n) onehot_decode[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter; owns the last-grant pointer.
// Search starts one past the last winner and wraps.
module apb_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] last;
  logic          found;

  // First requester after the last winner, modulo N.
  always_comb begin
    found = 1'b0;
    idx   = last;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(last) + i) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(last) + i) % N);
      end
    end
    gnt = found ? (N'(1) << idx) : '0;
  end

  // Pointer moves only when a grant is actually issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= IW'(N - 1);
    else if (en && found) last <= idx;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master sharing one bus among requesters: FSM, regs, resp mux.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int NUM_SLV     = 4,
  parameter int SLV_SEL_LSB = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                                 i_pclk,
  input  logic                                 i_prstn,
  input  logic [NUM_REQ-1:0]                   i_req,
  input  logic [NUM_REQ-1:0]                   i_req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]                   o_gnt,
  output logic [NUM_REQ-1:0]                   o_done,
  output logic [DATA_WIDTH-1:0]                o_rdata,
  output logic                                 o_err,
  output logic [ADDR_WIDTH-1:0]                o_paddr,
  output logic                                 o_pwrite,
  output logic [NUM_SLV-1:0]                   o_psel,
  output logic                                 o_penable,
  output logic [DATA_WIDTH-1:0]                o_pwdata,
  input  logic [NUM_SLV-1:0][DATA_WIDTH-1:0]   i_prdata,
  input  logic [NUM_SLV-1:0]                   i_pready,
  input  logic [NUM_SLV-1:0]                   i_pslverr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  apb_state_t          state;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic [IW-1:0]       win;
  logic [SW-1:0]       sidx;
  logic                mapped;
  logic [2:0]          dec_sel;
  logic [7:0]          dec_oh;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                rsp_ready;

`ifdef APB_TIMEOUT_EN
  localparam int TW = tmo_width(TIMEOUT);
  logic [TW-1:0] tcnt;
`endif

  apb_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .clk   (i_pclk),
    .rst_n (i_prstn),
    .req   (i_req),
    .en    (state == IDLE),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  assign dec_sel = 3'(i_req_addr[arb_idx][SLV_SEL_LSB +: SW]);
  assign dec_oh  = onehot_decode(dec_sel, NUM_SLV);

  // Mux response of the latched slave; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (sidx == SW'(s)) begin
        sel_ready = i_pready[s];
        sel_err   = i_pslverr[s];
        sel_rdata = i_prdata[s];
      end
    end
  end

  assign rsp_ready = mapped ? sel_ready : 1'b1;

  // IDLE -> SETUP -> ACCESS -> IDLE sequencing and APB registers.
  always_ff @(posedge i_pclk or negedge i_prstn) begin
    if (!i_prstn) begin
      state     <= IDLE;
      win       <= '0;
      sidx      <= '0;
      mapped    <= 1'b0;
      o_gnt     <= '0;
      o_done    <= '0;
      o_rdata   <= '0;
      o_err     <= 1'b0;
      o_paddr   <= '0;
      o_pwrite  <= 1'b0;
      o_psel    <= '0;
      o_penable <= 1'b0;
      o_pwdata  <= '0;
`ifdef APB_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      o_gnt  <= '0;
      o_done <= '0;
      unique case (state)
        IDLE: begin
          if (|i_req) begin
            o_paddr  <= i_req_addr[arb_idx];
            o_pwrite <= i_req_write[arb_idx];
            o_pwdata <= i_req_wdata[arb_idx];
            o_psel   <= dec_oh[NUM_SLV-1:0];
            o_gnt    <= arb_gnt;
            win      <= arb_idx;
            sidx     <= dec_sel[SW-1:0];
            mapped   <= |dec_oh;
            state    <= SETUP;
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          state     <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tcnt      <= '0;
`endif
        end
        ACCESS: begin
          if (rsp_ready) begin
            if (!o_pwrite) o_rdata <= mapped ? sel_rdata : '0;
            o_err     <= mapped ? sel_err : 1'b1;
            o_done    <= NUM_REQ'(1) << win;
            o_psel    <= '0;
            o_penable <= 1'b0;
            state     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            o_err     <= 1'b1;
            o_done    <= NUM_REQ'(1) << win;
            o_psel    <= '0;
            o_penable <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
